// File: rtl/core_seq_pkg.sv
// Shared definitions for the instruction sequencer: state encodings and
// architectural constants used by the FSM and its bench.
package core_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5,
        S_FAULT = 3'd6
    } seq_state_e;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [31:0] PC_STEP    = 32'd4;

    // ECALL/EBREAK share the SYSTEM opcode; either one stops the core.
    function automatic logic is_system(input logic [31:0] word);
        return word[6:0] == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/core_seq_timeout.sv
// Cycle counter bounding how long the sequencer waits for an IMEM response.
// expired_o rises in the LIMIT-th counted cycle, so a wait lasts at most LIMIT cycles.
module core_seq_timeout #(
    parameter int LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Clear has priority over counting; counting stops at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = 8'd0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register, cleared by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == 8'(LIMIT - 1));

endmodule

// File: rtl/core_seq.sv
// Multi-cycle fetch/execute/writeback sequencer for the single-issue datapath.
// Handshake: a request transfers on a cycle where imem_req_valid_o and
// imem_req_ready_i are both high; valid and address stay stable until then.
// The response is a single-cycle imem_rsp_valid_i pulse, only honoured in WAIT.
module core_seq
    import core_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          TIMEOUT  = 255,
    parameter int          RET_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             imem_req_valid_o,
    input  logic             imem_req_ready_i,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_rsp_valid_i,
    input  logic [31:0]      imem_rsp_data_i,
    output logic [31:0]      instr_o,
    input  logic             ctrl_rf_we_i,
    output logic             rf_we_o,
    output logic [31:0]      pc_o,
    output logic [RET_W-1:0] retired_o,
    output logic             halted_o,
    output logic             fault_o,
    output logic [2:0]       state_o
);

    seq_state_e       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      instr_q, instr_d;
    logic [RET_W-1:0] retired_q, retired_d;
    logic             wait_expired;

    // The counter restarts every time WAIT is entered and only advances
    // on cycles that pass without a response.
    core_seq_timeout #(
        .LIMIT(TIMEOUT)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q != S_WAIT),
        .en_i     ((state_q == S_WAIT) && !imem_rsp_valid_i),
        .expired_o(wait_expired)
    );

    // Next-state and datapath-register update logic for the sequencer.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (run_i) state_d = S_REQ;
            end
            S_REQ: begin
                if (imem_req_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A response arriving in the last allowed cycle still wins.
                if (imem_rsp_valid_i) begin
                    instr_d = imem_rsp_data_i;
                    state_d = S_EXEC;
                end else if (wait_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC: begin
                state_d = is_system(instr_q) ? S_HALT : S_WB;
            end
            S_WB: begin
                pc_d      = pc_q + PC_STEP;
                retired_d = retired_q + RET_W'(1);
                state_d   = run_i ? S_REQ : S_IDLE;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    // Sequencer registers; reset abandons any fetch in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= NOP_INSTR;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign imem_req_valid_o = (state_q == S_REQ);
    assign imem_addr_o      = pc_q;
    assign instr_o          = instr_q;
    assign rf_we_o          = (state_q == S_WB) && ctrl_rf_we_i;
    assign pc_o             = pc_q;
    assign retired_o        = retired_q;
    assign halted_o         = (state_q == S_HALT);
    assign fault_o          = (state_q == S_FAULT);
    assign state_o          = state_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: zero-wait fetches, stalled request, wait
// timeout, reset during WAIT, EBREAK halt, and PC wrap on a second instance.
module tb_core_seq;
    import core_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        ctrl_we = 1'b0;

    logic        req_valid, rf_we, halted, fault;
    logic [31:0] addr, instr, pc, retired;
    logic [2:0]  state;

    logic        req_valid2, rf_we2, halted2, fault2;
    logic [31:0] addr2, instr2, pc2, retired2;
    logic [2:0]  state2;

    int n_asrt = 0;
    int n_fail = 0;

    core_seq dut (
        .clk_i(clk), .rst_i(rst), .run_i(run),
        .imem_req_valid_o(req_valid), .imem_req_ready_i(req_ready),
        .imem_addr_o(addr), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .instr_o(instr), .ctrl_rf_we_i(ctrl_we), .rf_we_o(rf_we),
        .pc_o(pc), .retired_o(retired), .halted_o(halted), .fault_o(fault),
        .state_o(state)
    );

    core_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk_i(clk), .rst_i(rst), .run_i(run),
        .imem_req_valid_o(req_valid2), .imem_req_ready_i(req_ready),
        .imem_addr_o(addr2), .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
        .instr_o(instr2), .ctrl_rf_we_i(ctrl_we), .rf_we_o(rf_we2),
        .pc_o(pc2), .retired_o(retired2), .halted_o(halted2), .fault_o(fault2),
        .state_o(state2)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one instruction through REQ->WAIT->EXEC->WB with a zero-wait IMEM.
    // Entered with the DUT in REQ and req_ready high; returns with the DUT in WB.
    task automatic fetch(input logic [31:0] word, input logic we, input logic [31:0] exp_pc);
        chk("req_state", 32'(state), 32'(S_REQ));
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", addr, exp_pc);
        tick();
        chk("wait_state", 32'(state), 32'(S_WAIT));
        chk("wait_valid", 32'(req_valid), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = word;
        tick();
        rsp_valid = 1'b0;
        rsp_data  = 32'hDEAD_BEEF;
        ctrl_we   = we;
        chk("exec_state", 32'(state), 32'(S_EXEC));
        chk("exec_instr", instr, word);
        chk("exec_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("wb_state", 32'(state), 32'(S_WB));
        chk("wb_rf_we", 32'(rf_we), 32'(we));
        chk("wb_instr", instr, word);
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_retired", retired, 32'h0);
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pc_wrap", pc2, 32'hFFFF_FFFC);
        rst = 1'b0;
        tick();
        chk("idle_hold", 32'(state), 32'(S_IDLE));

        // Three zero-wait fetches: one instruction every 4 cycles
        run = 1'b1;
        req_ready = 1'b1;
        tick();
        fetch(32'h0010_0093, 1'b1, 32'h0);
        tick();
        ctrl_we = 1'b0;
        chk("after1_rf_we", 32'(rf_we), 32'd0);
        chk("after1_pc", pc, 32'h4);
        chk("after1_retired", retired, 32'd1);
        chk("wrap_pc", pc2, 32'h0);
        chk("wrap_addr", addr2, 32'h0);
        chk("wrap_retired", retired2, 32'd1);
        fetch(32'h0020_0113, 1'b0, 32'h4);
        tick();
        ctrl_we = 1'b0;
        fetch(32'h0030_0193, 1'b1, 32'h8);
        tick();
        ctrl_we = 1'b0;
        chk("after3_pc", pc, 32'hC);
        chk("after3_retired", retired, 32'd3);

        // Stalled request: valid/address held, no advance; run drop does not abort
        req_ready = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_state", 32'(state), 32'(S_REQ));
            chk("stall_valid", 32'(req_valid), 32'd1);
            chk("stall_addr", addr, 32'hC);
            tick();
        end
        req_ready = 1'b1;
        fetch(32'h0040_0213, 1'b1, 32'hC);
        tick();
        ctrl_we = 1'b0;
        chk("stop_state", 32'(state), 32'(S_IDLE));
        chk("stop_pc", pc, 32'h10);
        chk("stop_retired", retired, 32'd4);
        chk("stop_valid", 32'(req_valid), 32'd0);

        // Wait timeout: WAIT lasts at most 255 cycles, then FAULT
        run = 1'b1;
        tick();
        chk("to_req", 32'(state), 32'(S_REQ));
        tick();
        chk("to_wait", 32'(state), 32'(S_WAIT));
        for (int i = 0; i < 254; i++) tick();
        chk("to_still_wait", 32'(state), 32'(S_WAIT));
        chk("to_no_fault", 32'(fault), 32'd0);
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_fault_state", 32'(state), 32'(S_FAULT));
        for (int i = 0; i < 3; i++) tick();
        chk("to_absorb", 32'(fault), 32'd1);
        chk("to_no_req", 32'(req_valid), 32'd0);
        chk("to_pc", pc, 32'h10);

        // Reset during WAIT; a stale response afterwards must be ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_fault", 32'(fault), 32'd0);
        tick();
        tick();
        chk("rw_wait", 32'(state), 32'(S_WAIT));
        rst = 1'b1;
        run = 1'b0;
        tick();
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_data  = 32'h0050_0293;
        tick();
        rsp_valid = 1'b0;
        chk("rw_state", 32'(state), 32'(S_IDLE));
        chk("rw_instr", instr, NOP_INSTR);
        chk("rw_retired", retired, 32'd0);
        chk("rw_pc", pc, 32'h0);

        // EBREAK: halt with no writeback, pc and retired untouched
        run = 1'b1;
        tick();
        chk("eb_req", 32'(state), 32'(S_REQ));
        tick();
        rsp_valid = 1'b1;
        rsp_data  = 32'h0010_0073;
        tick();
        rsp_valid = 1'b0;
        ctrl_we   = 1'b1;
        chk("eb_exec", 32'(state), 32'(S_EXEC));
        chk("eb_exec_we", 32'(rf_we), 32'd0);
        tick();
        chk("eb_halted", 32'(halted), 32'd1);
        chk("eb_rf_we", 32'(rf_we), 32'd0);
        chk("eb_pc", pc, 32'h0);
        chk("eb_retired", retired, 32'd0);
        tick();
        tick();
        chk("eb_absorb", 32'(state), 32'(S_HALT));
        chk("eb_no_req", 32'(req_valid), 32'd0);
        chk("eb_rf_we2", 32'(rf_we), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
